// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Optional feature macro: FETCH_JAL_PREDICT_EN (JAL predecode in fetch_unit).
package fetch_pkg;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  // RV32 layout of one instruction-queue entry; fetch_unit builds the
  // same record with a PC field sized by its XLEN parameter.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred_taken;
  } fetch_entry_t;

  // J-type immediate, sign-extended to 32 bits.
  // Argument is instr[31:12]; the low 12 bits carry no immediate bits.
  function automatic logic signed [31:0] jal_imm(input logic [19:0] hi);
    return {{12{hi[19]}}, hi[7:0], hi[8], hi[18:9], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue: push, pop, flush, occupancy count.
// Flush dominates push and pop. The head reads as all-zero while empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter type entry_t = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = (count != '0) ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; flush behaves like a reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (do_pop && !do_push) count <= count - (PW+1)'(1);
    end
  end

  // Entry storage; contents need no reset because the head is gated by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one-outstanding request/response memory port,
// instruction queue, valid/ready hand-off to decode, redirect flush/squash.
// Optional feature macro: FETCH_JAL_PREDICT_EN (steer fetch on predecoded JAL).
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high (imem_req & imem_ready, out_valid & out_ready); imem_rvalid has no
// back-pressure and is only meaningful while a request is outstanding.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus_4,
  output logic            out_pred_taken
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic            outstanding;
  logic [XLEN-1:0] outstanding_pc;
  logic            stale;
  logic [CW-1:0]   count;
  logic [CW:0]     in_flight;
  logic            can_issue;
  logic            resp_fire;
  logic            resp_live;
  logic            is_jal;
  logic [XLEN-1:0] succ;
  logic            accept;
  logic            push;
  logic            pop;
  entry_t          push_data;
  entry_t          head;

  // A response only counts when a request is actually outstanding.
  assign resp_fire = imem_rvalid && outstanding;
  assign resp_live = resp_fire && !stale;

`ifdef FETCH_JAL_PREDICT_EN
  assign is_jal = (imem_rdata[6:0] == OPCODE_JAL);
  assign succ   = is_jal ? outstanding_pc + XLEN'(jal_imm(imem_rdata[31:12]))
                         : outstanding_pc + XLEN'(4);
`else
  assign is_jal = 1'b0;
  assign succ   = outstanding_pc + XLEN'(4);
`endif

  // Credit uses registered state only: queued entries plus the one in flight.
  assign in_flight = {1'b0, count} + {{CW{1'b0}}, outstanding};
  assign can_issue = in_flight < (CW+1)'(DEPTH);

  assign imem_req  = !rst && !redirect_valid && (!outstanding || imem_rvalid) && can_issue;
  assign imem_addr = resp_live ? succ : fetch_pc;
  assign accept    = imem_req && imem_ready;

  assign push      = resp_live && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push_data = '{instr: imem_rdata, pc: outstanding_pc, pred_taken: is_jal};

  // Fetch PC, outstanding-request tracking and stale-response squash.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      outstanding    <= 1'b0;
      outstanding_pc <= '0;
      stale          <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      outstanding <= outstanding && !imem_rvalid;
      stale       <= outstanding && !imem_rvalid;
    end else begin
      if (accept) begin
        outstanding    <= 1'b1;
        outstanding_pc <= imem_addr;
        fetch_pc       <= imem_addr;
      end else begin
        if (resp_fire) outstanding <= 1'b0;
        if (resp_live) fetch_pc    <= succ;
      end
      if (resp_fire && stale) stale <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign out_valid      = (count != '0);
  assign out_instr      = head.instr;
  assign out_pc         = head.pc;
  assign out_pc_plus_4  = out_valid ? head.pc + XLEN'(4) : '0;
  assign out_pred_taken = head.pred_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven streaming/back-pressure run,
// then hand-written redirect, JAL, reset and PC-wrap sequences.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic        out_pred_taken;

  // Second instance for the PC wrap case.
  logic        rst_w;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic        w_pred;

  int n_checks = 0;
  int n_fail   = 0;

  int          lat      = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr;
  logic        jal_at_8 = 1'b0;
  logic        w_pend   = 1'b0;
  logic [31:0] w_paddr;

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .out_pred_taken(out_pred_taken)
  );

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .out_valid(w_valid), .out_ready(1'b1), .out_instr(w_instr),
    .out_pc(w_pc), .out_pc_plus_4(w_pc4), .out_pred_taken(w_pred)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: unique non-JAL word per address, plus
  // an optional JAL x0,+0x40 at address 0x8.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (jal_at_8 && a == 32'h8) return 32'h0400_006F;
    return {a[24:0], 7'b0010011};
  endfunction

  // Memory responders: capture acceptance mid-cycle, answer after lat cycles.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    w_rvalid    = 1'b0;
    w_rdata     = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instr_of(pend_addr);
        end
      end
      w_rvalid = w_pend;
      w_rdata  = {w_paddr[24:0], 7'b0010011};
      w_pend   = 1'b0;
      @(negedge clk);
      if (imem_req && imem_ready) begin
        pend_cnt  = lat;
        pend_addr = imem_addr;
      end
      if (w_req) begin
        w_pend  = 1'b1;
        w_paddr = w_addr;
      end
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input logic v, input logic [31:0] pc);
    check({name, " out_valid"}, {31'b0, out_valid}, {31'b0, v});
    check({name, " out_pc"}, out_pc, v ? pc : 32'h0);
    check({name, " out_instr"}, out_instr, v ? instr_of(pc) : 32'h0);
    check({name, " out_pc_plus_4"}, out_pc_plus_4, v ? pc + 32'd4 : 32'h0);
  endtask

  // Two reset edges, check reset values, then leave the DUT in cycle c0.
  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    smp();
    check("rst imem_req", {31'b0, imem_req}, 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst out_pred_taken", {31'b0, out_pred_taken}, 32'h0);
    check_head("rst", 1'b0, 32'h0);
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        out_ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] jal_next;
    logic        jal_pred;
    bit          found;

    rst            = 1'b1;
    rst_w          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_ready     = 1'b1;
    out_ready      = 1'b1;

    // Streaming at one per cycle, then 5 cycles of back-pressure, then drain.
    tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[7]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
    tbl[8]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
    tbl[9]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
    tbl[10] = '{1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C};
    tbl[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[12] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[13] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
    tbl[14] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
    tbl[15] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

    lat = 1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      out_ready = tbl[i].out_ready;
      smp();
      check($sformatf("tbl[%0d] imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
      check($sformatf("tbl[%0d] imem_addr", i), imem_addr, tbl[i].exp_addr);
      check_head($sformatf("tbl[%0d]", i), tbl[i].exp_valid, tbl[i].exp_pc);
      cyc();
    end
    out_ready = 1'b1;

    // Redirect while the request to 0x20 is outstanding (3-cycle memory).
    lat = 3;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      smp();
      if (imem_req && imem_ready && imem_addr == 32'h20) found = 1'b1;
      else cyc();
    end
    check("stale: request to 0x20 seen", {31'b0, found}, 32'h1);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    smp();
    check("stale: redirect cycle imem_req", {31'b0, imem_req}, 32'h0);
    cyc();
    redirect_valid = 1'b0;
    smp();
    check("stale: waiting imem_req", {31'b0, imem_req}, 32'h0);
    check("stale: queue flushed", {31'b0, out_valid}, 32'h0);
    cyc();
    smp();
    check("stale: drop cycle imem_req", {31'b0, imem_req}, 32'h1);
    check("stale: drop cycle imem_addr", imem_addr, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      smp();
      if (out_valid) found = 1'b1;
    end
    check("stale: redirect target arrives", {31'b0, found}, 32'h1);
    check_head("stale: first entry", 1'b1, 32'h100);

    // Redirect coincident with a response and a pop.
    lat = 1;
    do_reset();
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    smp();
    check("coinc: rvalid present", {31'b0, imem_rvalid}, 32'h1);
    check("coinc: imem_req", {31'b0, imem_req}, 32'h0);
    cyc();
    redirect_valid = 1'b0;
    smp();
    check("coinc: out_valid next", {31'b0, out_valid}, 32'h0);
    check("coinc: imem_req next", {31'b0, imem_req}, 32'h1);
    check("coinc: imem_addr next", imem_addr, 32'h100);
    cyc();
    cyc();
    smp();
    check_head("coinc: target", 1'b1, 32'h100);

    // JAL at 0x8 with offset +0x40.
`ifdef FETCH_JAL_PREDICT_EN
    jal_next = 32'h48;
    jal_pred = 1'b1;
`else
    jal_next = 32'h0C;
    jal_pred = 1'b0;
`endif
    jal_at_8 = 1'b1;
    do_reset();
    repeat (3) cyc();
    smp();
    check("jal: successor addr", imem_addr, jal_next);
    cyc();
    smp();
    check_head("jal: entry", 1'b1, 32'h8);
    check("jal: out_instr word", out_instr, 32'h0400_006F);
    check("jal: pred flag", {31'b0, out_pred_taken}, {31'b0, jal_pred});
    cyc();
    smp();
    check_head("jal: next entry", 1'b1, jal_next);
    check("jal: next pred flag", {31'b0, out_pred_taken}, 32'h0);
    jal_at_8 = 1'b0;

    // Reset mid-transaction; the late response must be ignored.
    lat = 3;
    do_reset();
    cyc();
    rst        = 1'b1;
    imem_ready = 1'b0;
    smp();
    check("midrst: imem_req in reset", {31'b0, imem_req}, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();
    smp();
    check("midrst: stray rvalid present", {31'b0, imem_rvalid}, 32'h1);
    check("midrst: addr unaffected", imem_addr, 32'h0);
    check("midrst: imem_req", {31'b0, imem_req}, 32'h1);
    cyc();
    smp();
    check("midrst: nothing queued", {31'b0, out_valid}, 32'h0);
    imem_ready = 1'b1;
    lat = 1;

    // PC wrap on the second instance.
    cyc();
    rst_w = 1'b0;
    smp();
    check("wrap: first req", {31'b0, w_req}, 32'h1);
    check("wrap: first addr", w_addr, 32'hFFFF_FFFC);
    cyc();
    smp();
    check("wrap: second addr", w_addr, 32'h0);
    cyc();
    smp();
    check("wrap: out_valid", {31'b0, w_valid}, 32'h1);
    check("wrap: out_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap: out_pc_plus_4", w_pc4, 32'h0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
